// File: rtl/fx2_slavefifo_arbiter.sv
// FX2 Slave FIFO bus owner: round-robin time-sharing of the bus between the
// EP2 stream-out reader and the EP6 stream-in writer, with bounded bursts,
// bus turnaround between grants and PKTEND for short packets.
module fx2_slavefifo_arbiter #(
    parameter int BURST_MAX  = 256,
    parameter int TURNAROUND = 2
) (
    input  logic        fx2_ifclk,
    input  logic        reset_n,
    input  logic [15:0] fx2_fdata_in,
    output logic [15:0] fx2_fdata_out,
    output logic        fx2_fdata_oe,
    output logic [1:0]  fx2_faddr,
    output logic        fx2_slrd,
    output logic        fx2_slwr,
    output logic        fx2_sloe,
    output logic        fx2_pkt_end,
    output logic        fx2_slcs,
    input  logic        fx2_flagb,
    input  logic        fx2_flagc,
    input  logic        rx_ready,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    input  logic        tx_last,
    output logic        tx_ready
);

    localparam int CW = $clog2(BURST_MAX) + 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_SETUP = 3'd1;
    localparam logic [2:0] S_RD       = 3'd2;
    localparam logic [2:0] S_WR_SETUP = 3'd3;
    localparam logic [2:0] S_WR       = 3'd4;
    localparam logic [2:0] S_PKTEND   = 3'd5;
    localparam logic [2:0] S_TURN     = 3'd6;

    localparam logic [1:0] FADDR_EP2 = 2'b00;
    localparam logic [1:0] FADDR_EP6 = 2'b10;

    localparam logic [CW-1:0] BURST_LIM  = CW'(BURST_MAX);
    localparam logic [CW-1:0] BURST_LAST = CW'(BURST_MAX - 1);
    localparam logic [2:0]    TURN_LAST  = 3'(TURNAROUND - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    turn_q, turn_d;
    logic          last_wr_q, last_wr_d;   // 1 = last grant went to the writer
    logic [1:0]    faddr_q, faddr_d;
    logic [15:0]   rx_data_q;
    logic          rx_valid_q;

    logic below_max;
    logic rd_req, wr_req, grant_rd, grant_wr;
    logic rd_go, wr_go;

    // Strobes are gated by the live flags so a flag drop suppresses the
    // strobe in the same cycle: never read an empty or write a full FIFO.
    assign below_max = (count_q < BURST_LIM);
    assign rd_go     = (state_q == S_RD) & fx2_flagb & rx_ready & below_max;
    assign wr_go     = (state_q == S_WR) & tx_valid & fx2_flagc & below_max;

    assign rd_req   = fx2_flagb & rx_ready;
    assign wr_req   = tx_valid & fx2_flagc;
    assign grant_rd = rd_req & (~wr_req | last_wr_q);
    assign grant_wr = wr_req & ~grant_rd;

    assign fx2_slrd      = ~rd_go;
    assign fx2_slwr      = ~wr_go;
    assign tx_ready      = wr_go;
    assign fx2_sloe      = ~((state_q == S_RD_SETUP) | (state_q == S_RD));
    assign fx2_fdata_oe  = (state_q == S_WR_SETUP) | (state_q == S_WR) | (state_q == S_PKTEND);
    assign fx2_pkt_end   = ~(state_q == S_PKTEND);
    assign fx2_faddr     = faddr_q;
    assign fx2_fdata_out = tx_data;
    assign fx2_slcs      = 1'b0;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;

    // Next-state, burst counter, turnaround counter and grant history.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        count_d   = count_q;
        turn_d    = turn_q;
        last_wr_d = last_wr_q;
        faddr_d   = faddr_q;
        case (state_q)
            S_IDLE: begin
                if (grant_rd) begin
                    state_d   = S_RD_SETUP;
                    last_wr_d = 1'b0;
                    faddr_d   = FADDR_EP2;
                end else if (grant_wr) begin
                    state_d   = S_WR_SETUP;
                    last_wr_d = 1'b1;
                    faddr_d   = FADDR_EP6;
                end
            end
            S_RD_SETUP: begin
                count_d = '0;
                state_d = S_RD;
            end
            S_RD: begin
                if (rd_go) begin
                    count_d = count_q + CW'(1);
                end
                // Leave on the cycle of the final strobe so a full burst has
                // no dead cycle before turnaround.
                if (!rd_go || count_q == BURST_LAST) begin
                    state_d = S_TURN;
                    turn_d  = '0;
                end
            end
            S_WR_SETUP: begin
                count_d = '0;
                state_d = S_WR;
            end
            S_WR: begin
                if (wr_go) begin
                    count_d = count_q + CW'(1);
                end
                if (wr_go && tx_last) begin
                    state_d = S_PKTEND;
                end else if (!wr_go || count_q == BURST_LAST) begin
                    state_d = S_TURN;
                    turn_d  = '0;
                end
            end
            S_PKTEND: begin
                state_d = S_TURN;
                turn_d  = '0;
            end
            S_TURN: begin
                if (turn_q == TURN_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    turn_d = turn_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state registers; reset drops every strobe immediately.
    always_ff @(posedge fx2_ifclk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from the same pre-edge values.
        if (!reset_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            turn_q    <= '0;
            last_wr_q <= 1'b1;
            faddr_q   <= FADDR_EP2;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            turn_q    <= turn_d;
            last_wr_q <= last_wr_d;
            faddr_q   <= faddr_d;
        end
    end

    // Read datapath: bus word and strobe registered every cycle, 1-cycle latency.
    always_ff @(posedge fx2_ifclk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_data_q  <= fx2_fdata_in;
            rx_valid_q <= rd_go;
        end
    end

endmodule

// File: tb/tb_fx2_slavefifo_arbiter.sv
// Directed bench for fx2_slavefifo_arbiter: reset state, read burst, short
// write packet with PKTEND, burst-limit alternation, flag collision, rx_ready
// drop and reset during a read.
module tb_fx2_slavefifo_arbiter;

    localparam int BURST = 256;
    localparam int TURN  = 2;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } tx_word_t;

    logic        fx2_ifclk = 1'b0;
    logic        reset_n;
    logic [15:0] fx2_fdata_in;
    logic [15:0] fx2_fdata_out;
    logic        fx2_fdata_oe;
    logic [1:0]  fx2_faddr;
    logic        fx2_slrd, fx2_slwr, fx2_sloe, fx2_pkt_end, fx2_slcs;
    logic        fx2_flagb, fx2_flagc;
    logic        rx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic [15:0] tx_data;
    logic        tx_valid, tx_last, tx_ready;

    int total = 0;
    int bad   = 0;

    // bus observations gathered by step()
    tx_word_t    tx_q[$];
    logic [15:0] wr_log[$];
    int          run_dir[$], run_len[$], run_gap[$];
    bit          tx_en;
    bit          rd_pend, pe_prev;
    logic [15:0] rd_pend_data;
    int rd_cnt, wr_cnt, pe_cnt, rxv_cnt, oe_cnt;
    int rxv_err, rxd_err, addr_err, rdy_err, ovl_err, pe_oe_err;
    int gap_cnt, prev_dir;

    fx2_slavefifo_arbiter #(.BURST_MAX(BURST), .TURNAROUND(TURN)) dut (
        .fx2_ifclk     (fx2_ifclk),
        .reset_n       (reset_n),
        .fx2_fdata_in  (fx2_fdata_in),
        .fx2_fdata_out (fx2_fdata_out),
        .fx2_fdata_oe  (fx2_fdata_oe),
        .fx2_faddr     (fx2_faddr),
        .fx2_slrd      (fx2_slrd),
        .fx2_slwr      (fx2_slwr),
        .fx2_sloe      (fx2_sloe),
        .fx2_pkt_end   (fx2_pkt_end),
        .fx2_slcs      (fx2_slcs),
        .fx2_flagb     (fx2_flagb),
        .fx2_flagc     (fx2_flagc),
        .rx_ready      (rx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_last       (tx_last),
        .tx_ready      (tx_ready)
    );

    always #5 fx2_ifclk = ~fx2_ifclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_tx();
        tx_valid = tx_en && (tx_q.size() > 0);
        tx_data  = (tx_q.size() > 0) ? tx_q[0].data : 16'h0000;
        tx_last  = (tx_q.size() > 0) ? tx_q[0].last : 1'b0;
    endtask

    task automatic clear_stats();
        rd_cnt = 0; wr_cnt = 0; pe_cnt = 0; rxv_cnt = 0; oe_cnt = 0;
        rxv_err = 0; rxd_err = 0; addr_err = 0; rdy_err = 0; ovl_err = 0; pe_oe_err = 0;
        gap_cnt = 0; prev_dir = 0; pe_prev = 0;
        wr_log.delete(); run_dir.delete(); run_len.delete(); run_gap.delete();
    endtask

    // One clock: observe on the falling edge, update inputs 1 ns after the rising edge.
    task automatic step();
        bit pop;
        int dir;
        @(negedge fx2_ifclk);
        dir = 0;
        pop = 0;
        if (rx_valid) rxv_cnt++;
        if (rx_valid !== rd_pend) rxv_err++;
        if (rd_pend && rx_data !== rd_pend_data) rxd_err++;
        rd_pend      = !fx2_slrd;
        rd_pend_data = fx2_fdata_in;
        if (!fx2_slrd) begin
            rd_cnt++;
            dir = 1;
            if (fx2_faddr !== 2'b00 || fx2_sloe !== 1'b0) addr_err++;
        end
        if (!fx2_slwr) begin
            wr_cnt++;
            dir = 2;
            pop = 1;
            if (fx2_faddr !== 2'b10 || fx2_fdata_oe !== 1'b1) addr_err++;
            wr_log.push_back(fx2_fdata_out);
        end
        if (tx_ready !== !fx2_slwr) rdy_err++;
        if (!fx2_slrd && !fx2_slwr) ovl_err++;
        if (fx2_fdata_oe && !fx2_sloe) ovl_err++;
        if (fx2_slcs !== 1'b0) ovl_err++;
        if (fx2_fdata_oe) oe_cnt++;
        if (pe_prev && fx2_fdata_oe) pe_oe_err++;
        if (!fx2_pkt_end) begin
            pe_cnt++;
            if (fx2_faddr !== 2'b10 || !fx2_slwr || !fx2_fdata_oe) addr_err++;
        end
        pe_prev = !fx2_pkt_end;
        if (dir != 0) begin
            if (dir != prev_dir) begin
                run_dir.push_back(dir);
                run_len.push_back(1);
                run_gap.push_back(gap_cnt);
            end else begin
                run_len[run_len.size()-1]++;
            end
            gap_cnt = 0;
        end else begin
            gap_cnt++;
        end
        prev_dir = dir;
        @(posedge fx2_ifclk);
        #1;
        if (pop && tx_q.size() > 0) tx_q.delete(0);
        fx2_fdata_in = fx2_fdata_in + 16'h1357;
        drive_tx();
    endtask

    task automatic drain();
        fx2_flagb = 1'b0;
        rx_ready  = 1'b0;
        fx2_flagc = 1'b0;
        tx_en     = 1'b0;
        drive_tx();
        repeat (8) step();
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        fx2_fdata_in = 16'hFFFF;
        fx2_flagb    = 1'b0;
        fx2_flagc    = 1'b0;
        rx_ready     = 1'b0;
        tx_en        = 1'b0;
        rd_pend      = 1'b0;
        rd_pend_data = 16'h0000;
        tx_q.delete();
        drive_tx();
        clear_stats();
        repeat (2) @(posedge fx2_ifclk);
        #1;
        total++; if (fx2_slrd !== 1'b1) begin bad++; $display("FAIL reset_slrd got=%b exp=1", fx2_slrd); end
        total++; if (fx2_slwr !== 1'b1) begin bad++; $display("FAIL reset_slwr got=%b exp=1", fx2_slwr); end
        total++; if (fx2_sloe !== 1'b1) begin bad++; $display("FAIL reset_sloe got=%b exp=1", fx2_sloe); end
        total++; if (fx2_pkt_end !== 1'b1) begin bad++; $display("FAIL reset_pkt_end got=%b exp=1", fx2_pkt_end); end
        total++; if (fx2_fdata_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", fx2_fdata_oe); end
        total++; if (fx2_faddr !== 2'b00) begin bad++; $display("FAIL reset_faddr got=%b exp=00", fx2_faddr); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        total++; if (rx_data !== 16'h0000) begin bad++; $display("FAIL reset_rx_data got=%h exp=0000", rx_data); end
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL reset_tx_ready got=%b exp=0", tx_ready); end
        total++; if (fx2_slcs !== 1'b0) begin bad++; $display("FAIL reset_slcs got=%b exp=0", fx2_slcs); end
        @(negedge fx2_ifclk);
        reset_n = 1'b1;
        repeat (4) step();
        total++; if (rd_cnt + wr_cnt + oe_cnt != 0) begin bad++; $display("FAIL idle_no_activity got=%0d exp=0", rd_cnt + wr_cnt + oe_cnt); end
        total++; if (fx2_sloe !== 1'b1) begin bad++; $display("FAIL idle_sloe got=%b exp=1", fx2_sloe); end
    endtask

    task automatic test_burst_limit();
        int derr;
        int n;
        clear_stats();
        for (int i = 0; i < 600; i++) tx_q.push_back('{data: 16'h4000 + 16'(i), last: 1'b0});
        fx2_flagb = 1'b1;
        rx_ready  = 1'b1;
        fx2_flagc = 1'b1;
        tx_en     = 1'b1;
        drive_tx();
        for (int k = 0; k < 2000; k++) begin
            step();
            if (run_dir.size() == 3 && run_len[2] == BURST) break;
        end
        drain();
        tx_q.delete();
        n = run_dir.size();
        total++; if (n != 3) begin bad++; $display("FAIL burst_grants got=%0d exp=3", n); end
        if (n == 3) begin
            total++; if (run_dir[0] != 1 || run_dir[1] != 2 || run_dir[2] != 1)
                begin bad++; $display("FAIL burst_order got=%0d,%0d,%0d exp=1,2,1", run_dir[0], run_dir[1], run_dir[2]); end
            total++; if (run_len[0] != BURST || run_len[1] != BURST || run_len[2] != BURST)
                begin bad++; $display("FAIL burst_len got=%0d,%0d,%0d exp=%0d", run_len[0], run_len[1], run_len[2], BURST); end
            total++; if (run_gap[1] != TURN + 2 || run_gap[2] != TURN + 2)
                begin bad++; $display("FAIL burst_gap got=%0d,%0d exp=%0d", run_gap[1], run_gap[2], TURN + 2); end
        end
        derr = 0;
        for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] !== 16'h4000 + 16'(i)) derr++;
        total++; if (wr_cnt != BURST || derr != 0) begin bad++; $display("FAIL burst_wr_data got=%0d words %0d bad exp=%0d words 0 bad", wr_cnt, derr, BURST); end
        total++; if (rxd_err + rxv_err != 0) begin bad++; $display("FAIL burst_rx_path got=%0d exp=0", rxd_err + rxv_err); end
        total++; if (ovl_err + addr_err + rdy_err != 0) begin bad++; $display("FAIL burst_bus_rules got=%0d exp=0", ovl_err + addr_err + rdy_err); end
    endtask

    task automatic test_read();
        int hi;
        clear_stats();
        fx2_flagb = 1'b1;
        rx_ready  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            if (rd_cnt == 10) break;
        end
        fx2_flagb = 1'b0;
        step();
        fx2_flagb = 1'b1;
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            if (!fx2_sloe) break;
            hi++;
            step();
        end
        fx2_flagb = 1'b0;
        drain();
        total++; if (rd_cnt != 10) begin bad++; $display("FAIL read_strobes got=%0d exp=10", rd_cnt); end
        total++; if (rxv_cnt != 10) begin bad++; $display("FAIL read_rx_valid got=%0d exp=10", rxv_cnt); end
        total++; if (rxd_err + rxv_err != 0) begin bad++; $display("FAIL read_rx_path got=%0d exp=0", rxd_err + rxv_err); end
        total++; if (oe_cnt != 0) begin bad++; $display("FAIL read_oe got=%0d exp=0", oe_cnt); end
        total++; if (addr_err + ovl_err != 0) begin bad++; $display("FAIL read_bus_rules got=%0d exp=0", addr_err + ovl_err); end
        total++; if (hi != TURN + 1) begin bad++; $display("FAIL read_turnaround got=%0d exp=%0d", hi, TURN + 1); end
    endtask

    task automatic test_write_short();
        int derr;
        clear_stats();
        for (int i = 0; i < 5; i++) tx_q.push_back('{data: 16'hB000 + 16'(i), last: (i == 4)});
        fx2_flagc = 1'b1;
        tx_en     = 1'b1;
        drive_tx();
        for (int k = 0; k < 60; k++) begin
            step();
            if (pe_cnt == 1) break;
        end
        drain();
        derr = 0;
        for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] !== 16'hB000 + 16'(i)) derr++;
        total++; if (wr_cnt != 5) begin bad++; $display("FAIL short_strobes got=%0d exp=5", wr_cnt); end
        total++; if (derr != 0) begin bad++; $display("FAIL short_data got=%0d bad exp=0", derr); end
        total++; if (pe_cnt != 1) begin bad++; $display("FAIL short_pkt_end got=%0d exp=1", pe_cnt); end
        total++; if (pe_oe_err != 0) begin bad++; $display("FAIL short_oe_after_pkt_end got=%0d exp=0", pe_oe_err); end
        total++; if (addr_err + rdy_err + rd_cnt != 0) begin bad++; $display("FAIL short_bus_rules got=%0d exp=0", addr_err + rdy_err + rd_cnt); end
        total++; if (tx_q.size() != 0) begin bad++; $display("FAIL short_fifo_left got=%0d exp=0", tx_q.size()); end
    endtask

    task automatic test_flag_collision();
        int derr;
        clear_stats();
        for (int i = 0; i < 4; i++) tx_q.push_back('{data: 16'hD000 + 16'(i), last: 1'b0});
        fx2_flagc = 1'b1;
        tx_en     = 1'b1;
        drive_tx();
        for (int k = 0; k < 40; k++) begin
            step();
            if (wr_cnt == 2) break;
        end
        fx2_flagc = 1'b0;
        #1;
        total++; if (fx2_slwr !== 1'b1) begin bad++; $display("FAIL collide_slwr got=%b exp=1", fx2_slwr); end
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL collide_tx_ready got=%b exp=0", tx_ready); end
        repeat (6) step();
        fx2_flagc = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (wr_cnt == 4) break;
        end
        drain();
        derr = 0;
        for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] !== 16'hD000 + 16'(i)) derr++;
        total++; if (wr_cnt != 4 || derr != 0) begin bad++; $display("FAIL collide_no_loss got=%0d words %0d bad exp=4 words 0 bad", wr_cnt, derr); end
        total++; if (rdy_err + addr_err != 0) begin bad++; $display("FAIL collide_bus_rules got=%0d exp=0", rdy_err + addr_err); end
    endtask

    task automatic test_rx_ready_drop();
        clear_stats();
        fx2_flagb = 1'b1;
        rx_ready  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (rd_cnt == 3) break;
        end
        rx_ready = 1'b0;
        #1;
        total++; if (fx2_slrd !== 1'b1) begin bad++; $display("FAIL rxdrop_slrd got=%b exp=1", fx2_slrd); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL rxdrop_trailing got=%b exp=1", rx_valid); end
        step();
        total++; if (rx_valid !== 1'b0 || fx2_sloe !== 1'b1) begin bad++; $display("FAIL rxdrop_turn got=%b%b exp=01", rx_valid, fx2_sloe); end
        drain();
        total++; if (rd_cnt != 3 || rxv_cnt != 3 || rxv_err != 0) begin bad++; $display("FAIL rxdrop_counts got=%0d/%0d/%0d exp=3/3/0", rd_cnt, rxv_cnt, rxv_err); end
    endtask

    task automatic test_reset_mid_read();
        clear_stats();
        fx2_flagb = 1'b1;
        rx_ready  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (rd_cnt == 5) break;
        end
        for (int i = 0; i < 3; i++) tx_q.push_back('{data: 16'hE000 + 16'(i), last: 1'b0});
        fx2_flagc = 1'b1;
        tx_en     = 1'b1;
        drive_tx();
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (fx2_slrd !== 1'b1 || fx2_sloe !== 1'b1) begin bad++; $display("FAIL midreset_strobes got=%b%b exp=11", fx2_slrd, fx2_sloe); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL midreset_rx_valid got=%b exp=0", rx_valid); end
        rd_pend = 1'b0;
        @(posedge fx2_ifclk);
        @(posedge fx2_ifclk);
        #3;
        reset_n = 1'b1;
        #1;
        total++; if (fx2_sloe !== 1'b1 || fx2_fdata_oe !== 1'b0 || fx2_faddr !== 2'b00)
            begin bad++; $display("FAIL midreset_idle got=%b%b%b exp=1000", fx2_sloe, fx2_fdata_oe, fx2_faddr); end
        clear_stats();
        for (int k = 0; k < 20; k++) begin
            step();
            if (rd_cnt + wr_cnt > 0) break;
        end
        total++; if (rd_cnt != 1 || wr_cnt != 0) begin bad++; $display("FAIL midreset_first_grant got=rd%0d wr%0d exp=rd1 wr0", rd_cnt, wr_cnt); end
        drain();
        tx_q.delete();
        drive_tx();
    endtask

    initial begin
        test_reset();
        test_burst_limit();
        test_read();
        test_write_short();
        test_flag_collision();
        test_rx_ready_drop();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fx2_slavefifo_arbiter.md
Name: fx2_slavefifo_arbiter

Overview:
Owns the FX2 Slave FIFO bus and time-shares it between two users. The stream-out consumer reads EP2 (faddr 00). The stream-in producer writes EP6 (faddr 10). The block arbitrates round-robin, bounds each grant to a burst, inserts bus turnaround and issues PKTEND for short packets. It sits between the FX2 pins and the FPGA-side FIFOs (SDRAM path) and replaces per-direction pin drivers.

Parameters:
BURST_MAX, 256, maximum words transferred per grant before re-arbitration (power of 2, 2..1024)
TURNAROUND, 2, idle cycles with all strobes high and bus released between grants (1..7)

Ports:
fx2_ifclk  in  1  interface clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
fx2_fdata_in  in  16  FX2 data bus, input side
fx2_fdata_out  out  16  FX2 data bus, output side
fx2_fdata_oe  out  1  1 = FPGA drives the bus (tristate control for the top level)
fx2_faddr  out  2  FIFO address: 00 = EP2, 10 = EP6
fx2_slrd  out  1  read strobe, active low
fx2_slwr  out  1  write strobe, active low
fx2_sloe  out  1  FX2 output enable, active low
fx2_pkt_end  out  1  packet end, active low
fx2_slcs  out  1  chip select, tied 0
fx2_flagb  in  1  EP2 not-empty, active high
fx2_flagc  in  1  EP6 not-full, active high
rx_ready  in  1  consumer can accept at least BURST_MAX words
rx_data  out  16  word read from EP2
rx_valid  out  1  rx_data valid, single-cycle qualifier
tx_data  in  16  word to write to EP6
tx_valid  in  1  tx_data available (show-ahead FIFO)
tx_last  in  1  with tx_valid: last word of a short packet, commit with PKTEND
tx_ready  out  1  tx word consumed this cycle (FIFO pop)

Behaviour:
- Reset values:
  - state IDLE; fx2_slrd, fx2_slwr, fx2_sloe, fx2_pkt_end = 1.
  - fx2_fdata_oe = 0; fx2_faddr = 00.
  - rx_data = 0; rx_valid = 0; burst count = 0; last_grant = WR.
- Reset mid-operation: strobes go inactive asynchronously. A partial packet is not flushed.
- Requests, evaluated in IDLE:
  - rd_req = flagb & rx_ready
  - wr_req = tx_valid & flagc
  - Both active: grant the direction opposite last_grant. After reset, read wins first.
  - last_grant updates on entry to RD_SETUP or WR_SETUP.
- States:
  - IDLE -> RD_SETUP or WR_SETUP on grant; otherwise stay.
  - RD_SETUP (1 cycle): faddr = 00, sloe = 0, oe = 0, count cleared -> RD.
  - RD: sloe = 0. Combinational slrd = ~(flagb & rx_ready & count < BURST_MAX). count increments per strobe. Exit to TURN when flagb = 0, rx_ready = 0, or count reaches BURST_MAX.
  - WR_SETUP (1 cycle): faddr = 10, oe = 1, count cleared -> WR.
  - WR: oe = 1. Combinational slwr = ~(tx_valid & flagc & count < BURST_MAX). tx_ready = ~slwr. fx2_fdata_out = tx_data.
    - Word written with tx_last = 1 -> PKTEND.
    - Else exit to TURN when flagc = 0, tx_valid = 0, or count reaches BURST_MAX.
  - PKTEND (1 cycle): pkt_end = 0, faddr = 10, oe = 1, no slwr -> TURN.
  - TURN: all strobes high, sloe = 1, oe = 0, faddr held. TURNAROUND cycles, then -> IDLE.
- Flag drop coincident with a strobe: the strobe is gated combinationally the same cycle. No read from an empty FIFO or write to a full FIFO.
- Read datapath: rx_data <= fx2_fdata_in and rx_valid <= ~slrd every cycle. Latency is 1 cycle from strobe to rx_valid.
- Write datapath: zero latency; the word is presented in the same cycle as tx_ready.
- Counter width: clog2(BURST_MAX)+1 bits, no wrap. Equality with BURST_MAX terminates the burst.
- sloe and oe are never active together. oe asserts at least TURNAROUND cycles after sloe deasserts, and vice versa.

Test Plan:
- Read only: flagb = 1 and rx_ready = 1 for 10 words, then flagb drops -> exactly 10 rx_valid pulses with data matching the bus; faddr = 00; oe never 1; then TURN for 2 cycles.
- Write short packet: tx_valid with 5 words, tx_last on word 5 -> 5 slwr pulses with faddr = 10, then one pkt_end low cycle, then oe = 0.
- Burst limit: both requests held continuously with BURST_MAX = 256 -> grants alternate RD, WR, RD; each grant is exactly 256 strobes, separated by setup and turnaround cycles.
- Flag collision: flagc drops in the same cycle as a pending write -> slwr stays high that cycle, tx_ready = 0, and no word is lost (tx_data is still presented on the next grant).
- Reset mid-read: reset_n pulses low during RD -> slrd and sloe go high immediately, rx_valid goes low; after release, state is IDLE and the first grant is a read.
- rx_ready deasserts mid-burst -> slrd goes high the same cycle; one trailing rx_valid follows, then TURN.
